gfx_rect_fill: RTL and testbench

Parametrised rectangle-fill engine for the graphics pipeline. It is the next-generation RRECT backend.
- Accepts a rect command and a latched framebuffer/scissor state.
- Clips the rect to framebuffer bounds and, optionally, the scissor.
- Emits aligned, byte-strobed VRAM stores of configurable width, in ARGB8888 or RGB565.
- Sits between the gfx command decoder and the gfx store port (gfx_st_*).

---
 rtl/gfx_rect_fill.sv | 134 +++++++++++++
 tb/tb_gfx_rect_fill.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_rect_fill.sv
// gfx_rect_fill: clips a rect to framebuffer/scissor and emits aligned byte-strobed VRAM stores.
// Optional GFX_RECT_BLEND_EN adds blend_en/st_rmw for downstream ROP blending.
module gfx_rect_fill #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int COORD_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [COORD_W-1:0]    cmd_x0,
  input  logic [COORD_W-1:0]    cmd_y0,
  input  logic [COORD_W-1:0]    cmd_x1,
  input  logic [COORD_W-1:0]    cmd_y1,
  input  logic [31:0]           cmd_color,
  input  logic [ADDR_W-1:0]     fb_base,
  input  logic [ADDR_W-1:0]     fb_stride,
  input  logic                  fb_format,
  input  logic [COORD_W-1:0]    fb_w,
  input  logic [COORD_W-1:0]    fb_h,
  input  logic [COORD_W-1:0]    sc_x0,
  input  logic [COORD_W-1:0]    sc_y0,
  input  logic [COORD_W-1:0]    sc_w,
  input  logic [COORD_W-1:0]    sc_h,
  input  logic                  sc_en,
`ifdef GFX_RECT_BLEND_EN
  input  logic                  blend_en,
  output logic                  st_rmw,
`endif
  output logic                  st_valid,
  input  logic                  st_ready,
  output logic [ADDR_W-1:0]     st_addr,
  output logic [DATA_W-1:0]     st_wdata,
  output logic [DATA_W/8-1:0]   st_wstrb,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           px_count
);
  localparam int NB = DATA_W / 8;
  localparam int CW = COORD_W + 1;
  typedef enum logic [2:0] {IDLE, CLIP, ROW, BEAT, FIN} state_t;
  state_t state, state_nx;
  logic [COORD_W-1:0] x0, y0, x1, y1, fw, fh, sx, sy, sw, sh;
  logic [31:0] color;
  logic [ADDR_W-1:0] base, stride, beat_addr, start_b, end_b;
  logic fmt, scen, empty;
  logic [CW-1:0] cx0, cx1, cy0, cy1, y;
  logic [CW-1:0] lx0, lx1, ly0, ly1, tx1, ty1, sxe, sye;
  logic [ADDR_W-1:0] row_a, s_a, e_a, nb;
  logic [1:0] sh_amt;
  logic [15:0] p565;
  logic [31:0] lane;
`ifdef GFX_RECT_BLEND_EN
  logic blend;
  assign st_rmw = st_valid && blend;
`endif
  // scissor extents are one bit wider than coordinates so sx+sw never wraps
  assign sxe = CW'(sx) + CW'(sw);
  assign sye = CW'(sy) + CW'(sh);
  assign lx0 = (scen && CW'(sx) > CW'(x0)) ? CW'(sx) : CW'(x0);
  assign ly0 = (scen && CW'(sy) > CW'(y0)) ? CW'(sy) : CW'(y0);
  assign tx1 = (x1 < fw) ? CW'(x1) : CW'(fw);
  assign ty1 = (y1 < fh) ? CW'(y1) : CW'(fh);
  assign lx1 = (scen && sxe < tx1) ? sxe : tx1;
  assign ly1 = (scen && sye < ty1) ? sye : ty1;
  assign sh_amt = fmt ? 2'd1 : 2'd2;
  assign row_a = base + ADDR_W'(y) * stride;
  assign s_a = row_a + (ADDR_W'(cx0) << sh_amt);
  assign e_a = row_a + (ADDR_W'(cx1) << sh_amt);
  assign nb = beat_addr + ADDR_W'(NB);
  assign p565 = {color[23:19], color[15:10], color[7:3]};
  assign lane = fmt ? {2{p565}} : color;
  assign cmd_ready = state == IDLE;
  assign busy = !cmd_ready;
  assign st_valid = state == BEAT;
  assign done = state == FIN && !flush;
  assign st_addr = st_valid ? beat_addr : '0;
  assign st_wdata = st_valid ? {(DATA_W/32){lane}} : '0;
  always_comb begin
    st_wstrb = '0;
    for (int i = 0; i < NB; i++)
      st_wstrb[i] = st_valid && (beat_addr + ADDR_W'(i) >= start_b) && (beat_addr + ADDR_W'(i) < end_b);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = cmd_valid ? CLIP : IDLE;
      CLIP: state_nx = (lx1 <= lx0 || ly1 <= ly0) ? FIN : ROW;
      ROW:  state_nx = BEAT;
      BEAT: state_nx = (st_ready && nb >= end_b) ? ((y + CW'(1) < cy1) ? ROW : FIN) : BEAT;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {x0, y0, x1, y1, fw, fh, sx, sy, sw, sh} <= '0;
      {color, base, stride, fmt, scen, empty} <= '0;
      {cx0, cx1, cy0, cy1, y} <= '0;
      {beat_addr, start_b, end_b} <= '0;
      px_count <= '0;
`ifdef GFX_RECT_BLEND_EN
      blend <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid && !flush) begin
        {x0, y0, x1, y1, color} <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
        {base, stride, fmt, fw, fh} <= {fb_base, fb_stride, fb_format, fb_w, fb_h};
        {sx, sy, sw, sh, scen} <= {sc_x0, sc_y0, sc_w, sc_h, sc_en};
`ifdef GFX_RECT_BLEND_EN
        blend <= blend_en;
`endif
      end
      if (state == CLIP) begin
        {cx0, cx1, cy0, cy1, y} <= {lx0, lx1, ly0, ly1, ly0};
        empty <= lx1 <= lx0 || ly1 <= ly0;
      end
      if (state == ROW) begin
        beat_addr <= s_a & ~ADDR_W'(NB - 1);
        start_b <= s_a;
        end_b <= e_a;
      end
      if (state == BEAT && st_ready) begin
        beat_addr <= nb;
        if (nb >= end_b) y <= y + CW'(1);
      end
      if (state == FIN && !flush) px_count <= empty ? '0 : 32'(cx1 - cx0) * 32'(cy1 - cy0);
    end
  end
endmodule

// File: tb/tb_gfx_rect_fill.sv
// tb_gfx_rect_fill: directed vectors against 32-bit and 128-bit beat instances of gfx_rect_fill.
module tb_gfx_rect_fill;
  logic clk = 0, rst_n = 0, flush = 0, cv0 = 0, cv1 = 0, st_ready = 0;
  logic [15:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1, fb_w, fb_h, sc_x0, sc_y0, sc_w, sc_h;
  logic [31:0] cmd_color, fb_base, fb_stride;
  logic fb_format = 0, sc_en = 0;
  logic r0, r1, v0, v1, b0, b1, d0, d1;
  logic [31:0] a0, a1, p0, p1, wd0;
  logic [127:0] wd1;
  logic [3:0] s0;
  logic [15:0] s1;
  bit sel;
  logic rdy, v, bz, dn;
  logic [31:0] a, pxc;
  logic [127:0] d;
  logic [15:0] ws;
  int checks = 0, errors = 0;
  logic [31:0] ea[$], ga[$];
  logic [15:0] es[$], gs[$];
  logic [127:0] ed[$], gd[$];
  int first, done_cyc, last_hs, unstable;
  logic [31:0] px_seen;

  always #5 clk = ~clk;

  gfx_rect_fill u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cmd_valid(cv0), .cmd_ready(r0),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .fb_base(fb_base), .fb_stride(fb_stride), .fb_format(fb_format), .fb_w(fb_w), .fb_h(fb_h),
    .sc_x0(sc_x0), .sc_y0(sc_y0), .sc_w(sc_w), .sc_h(sc_h), .sc_en(sc_en),
    .st_valid(v0), .st_ready(st_ready), .st_addr(a0), .st_wdata(wd0), .st_wstrb(s0),
    .busy(b0), .done(d0), .px_count(p0)
  );
  gfx_rect_fill #(.DATA_W(128)) u128 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cmd_valid(cv1), .cmd_ready(r1),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .fb_base(fb_base), .fb_stride(fb_stride), .fb_format(fb_format), .fb_w(fb_w), .fb_h(fb_h),
    .sc_x0(sc_x0), .sc_y0(sc_y0), .sc_w(sc_w), .sc_h(sc_h), .sc_en(sc_en),
    .st_valid(v1), .st_ready(st_ready), .st_addr(a1), .st_wdata(wd1), .st_wstrb(s1),
    .busy(b1), .done(d1), .px_count(p1)
  );

  assign rdy = sel ? r1 : r0;
  assign v = sel ? v1 : v0;
  assign bz = sel ? b1 : b0;
  assign dn = sel ? d1 : d0;
  assign a = sel ? a1 : a0;
  assign pxc = sel ? p1 : p0;
  assign d = sel ? wd1 : {96'b0, wd0};
  assign ws = sel ? s1 : {12'b0, s0};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic setup(input int x0, input int y0, input int x1, input int y1, input logic [31:0] col,
                       input bit fmt, input int stride, input bit scen);
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1} = {16'(x0), 16'(y0), 16'(x1), 16'(y1)};
    cmd_color = col;
    fb_format = fmt;
    fb_stride = 32'(stride);
    fb_base = 32'h2000;
    {fb_w, fb_h} = {16'd8, 16'd8};
    {sc_x0, sc_y0, sc_w, sc_h} = {16'd0, 16'd0, 16'd7, 16'd7};
    sc_en = scen;
    ea.delete(); es.delete(); ed.delete();
  endtask

  task automatic push(input logic [31:0] ad, input logic [15:0] st, input logic [127:0] dt);
    ea.push_back(ad); es.push_back(st); ed.push_back(dt);
  endtask

  task automatic run(input bit s, input bit bp, input int limit);
    int cyc;
    bit stalled;
    logic [31:0] ha;
    logic [15:0] hs;
    logic [127:0] hd;
    sel = s;
    ga.delete(); gs.delete(); gd.delete();
    first = 0; done_cyc = 0; last_hs = 0; unstable = 0; stalled = 0;
    {ha, hs, hd} = '0;
    @(negedge clk);
    if (s) cv1 = 1; else cv0 = 1;
    for (cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      cv0 = 0; cv1 = 0;
      if (cyc == 1) begin
        cmd_color = '1; fb_base = 32'h8000; cmd_x1 = 0;
      end
      st_ready = bp ? (cyc % 3 == 0) : 1'b1;
      #1;
      if (stalled && (!v || a !== ha || ws !== hs || d !== hd)) unstable++;
      if (v && first == 0) first = cyc;
      if (v && st_ready) begin
        ga.push_back(a); gs.push_back(ws); gd.push_back(d); last_hs = cyc;
      end
      stalled = v && !st_ready;
      {ha, hs, hd} = {a, ws, d};
      if (dn) begin
        done_cyc = cyc;
        break;
      end
      if (limit > 0 && ga.size() == limit) break;
    end
    chk("run_bound", 1'(done_cyc != 0 || (limit > 0 && ga.size() == limit)), 1'b1);
    if (done_cyc != 0) begin
      @(negedge clk);
      #1 px_seen = pxc;
    end
  endtask

  task automatic cmp(input string tag, input int px);
    chk({tag, "_count"}, ga.size(), ea.size());
    for (int i = 0; i < ea.size() && i < ga.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), ga[i], ea[i]);
      chk($sformatf("%s_strb%0d", tag, i), gs[i], es[i]);
      chk($sformatf("%s_data%0d", tag, i), gd[i], ed[i]);
    end
    chk({tag, "_px"}, px_seen, px);
    if (ea.size() > 0) begin
      chk({tag, "_first"}, first, 3);
      chk({tag, "_done_at"}, done_cyc, last_hs + 1);
    end
  endtask

  task automatic case1;
    setup(0, 0, 4, 4, 32'hAABBCCDD, 0, 32, 0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) push(32'h2000 + 32'(r * 32 + c * 4), 16'hF, {96'b0, 32'hAABBCCDD});
  endtask

  initial begin
    sel = 0;
    setup(0, 0, 4, 4, 32'hAABBCCDD, 0, 32, 0);
    #2;
    chk("rst_cmd_ready", rdy, 1);
    chk("rst_valid", v, 0);
    chk("rst_busy", bz, 0);
    chk("rst_done", dn, 0);
    chk("rst_px", pxc, 0);
    chk("rst_cmd_ready128", r1, 1);
    #20 rst_n = 1;

    case1;
    run(0, 0, 0);
    cmp("argb32", 16);

    setup(1, 0, 6, 1, 32'hAABBCCDD, 0, 32, 0);
    push(32'h2000, 16'hFFF0, {4{32'hAABBCCDD}});
    push(32'h2010, 16'h00FF, {4{32'hAABBCCDD}});
    run(1, 0, 0);
    cmp("argb128", 5);

    setup(0, 0, 2, 1, 32'h00FF0000, 1, 16, 0);
    push(32'h2000, 16'hF, {96'b0, 32'hF800F800});
    run(0, 0, 0);
    cmp("rgb565", 2);

    setup(6, 6, 20, 20, 32'h11223344, 0, 32, 0);
    push(32'h20D8, 16'hF, {96'b0, 32'h11223344});
    push(32'h20DC, 16'hF, {96'b0, 32'h11223344});
    push(32'h20F8, 16'hF, {96'b0, 32'h11223344});
    push(32'h20FC, 16'hF, {96'b0, 32'h11223344});
    run(0, 0, 0);
    cmp("clip_fb", 4);

    setup(6, 6, 20, 20, 32'h11223344, 0, 32, 1);
    push(32'h20D8, 16'hF, {96'b0, 32'h11223344});
    run(0, 0, 0);
    cmp("clip_sc", 1);

    setup(5, 5, 5, 9, 32'h11223344, 0, 32, 0);
    run(0, 0, 0);
    cmp("empty", 0);
    chk("empty_done_at", done_cyc, 2);
    chk("empty_no_valid", first, 0);

    case1;
    run(0, 1, 0);
    cmp("backpressure", 16);
    chk("bp_stable", unstable, 0);

    case1;
    run(0, 0, 5);
    chk("flush_stores", ga.size(), 5);
    @(negedge clk);
    flush = 1; st_ready = 0;
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_cmd_ready", rdy, 1);
    chk("flush_valid", v, 0);
    chk("flush_busy", bz, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #1 seen = seen | dn;
      end
      chk("flush_no_done", seen, 0);
    end
    chk("flush_px_kept", pxc, 16);

    case1;
    run(0, 0, 3);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_cmd_ready", rdy, 1);
    chk("arst_valid", v, 0);
    chk("arst_busy", bz, 0);
    chk("arst_done", dn, 0);
    chk("arst_px", pxc, 0);
    chk("arst_addr", a, 0);
    chk("arst_strb", ws, 0);
    chk("arst_data", d, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
